ysyx_22050078_wbu: RTL and testbench

Write-back unit: the producer side of the integer register file's write port and the consumer of its two read ports. It accepts results from EXU and LSU over valid/ready handshakes, arbitrates them onto the single register-file write port through one pipeline register, and tracks pending destinations in a 32-bit busy scoreboard. It forwards in-flight write data to the IDU's operand reads and signals operand and WAW hazards. It sits between EXU/LSU and the register file; the IDU sees it as the operand source.

---
 rtl/ysyx_22050078_wbu_pkg.sv | 26 ++
 rtl/ysyx_22050078_wbu_if.sv | 53 +++++
 rtl/ysyx_22050078_wbu_fwd.sv | 23 ++
 rtl/ysyx_22050078_wbu.sv | 99 +++++++++
 tb/tb_ysyx_22050078_wbu.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050078_wbu_pkg.sv
// Shared widths, constants and types for the write-back unit.
package ysyx_22050078_wbu_pkg;

  localparam int CPU_WIDTH = 64;
  localparam int REG_ADDRW = 5;
  localparam int REG_NUM   = 1 << REG_ADDRW;

  localparam logic [CPU_WIDTH-1:0] ZERO_WORD = '0;

  typedef logic [REG_ADDRW-1:0] reg_addr_t;
  typedef logic [CPU_WIDTH-1:0] word_t;

  // Which producer owns the write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_EXU,
    SRC_LSU
  } wb_src_e;

  typedef struct packed {
    logic      vld;
    reg_addr_t rd;
    word_t     data;
  } wb_entry_t;

endpackage

// File: rtl/ysyx_22050078_wbu_if.sv
// Bundle of issue, result, register-file and operand signals around the WBU.
interface ysyx_22050078_wbu_if;
  import ysyx_22050078_wbu_pkg::*;

  logic      iss_valid;
  reg_addr_t iss_rd;
  logic      iss_ready;

  logic      exu_valid;
  reg_addr_t exu_rd;
  word_t     exu_data;
  logic      exu_ready;

  logic      lsu_valid;
  reg_addr_t lsu_rd;
  word_t     lsu_data;
  logic      lsu_ready;

  logic      rf_wen;
  reg_addr_t rf_waddr;
  word_t     rf_wdata;
  reg_addr_t rf_rs1_addr;
  reg_addr_t rf_rs2_addr;
  word_t     rf_rs1_data;
  word_t     rf_rs2_data;

  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  word_t     rs1_data;
  word_t     rs2_data;
  logic      rs1_busy;
  logic      rs2_busy;

  logic      err;

  // Environment side: IDU, EXU, LSU and the register file.
  modport master (
    output iss_valid, iss_rd, exu_valid, exu_rd, exu_data,
           lsu_valid, lsu_rd, lsu_data, rf_rs1_data, rf_rs2_data,
           rs1_addr, rs2_addr,
    input  iss_ready, exu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata,
           rf_rs1_addr, rf_rs2_addr, rs1_data, rs2_data, rs1_busy, rs2_busy, err
  );

  modport slave (
    input  iss_valid, iss_rd, exu_valid, exu_rd, exu_data,
           lsu_valid, lsu_rd, lsu_data, rf_rs1_data, rf_rs2_data,
           rs1_addr, rs2_addr,
    output iss_ready, exu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata,
           rf_rs1_addr, rf_rs2_addr, rs1_data, rs2_data, rs1_busy, rs2_busy, err
  );

endinterface

// File: rtl/ysyx_22050078_wbu_fwd.sv
// Operand read mux: x0 reads zero, an in-flight write-back wins over the register file.
module ysyx_22050078_wbu_fwd
  import ysyx_22050078_wbu_pkg::*;
(
  input  reg_addr_t addr,
  input  word_t     rf_data,
  input  logic      wen,
  input  reg_addr_t wb_rd,
  input  word_t     wb_data,
  output word_t     data
);

  always_comb begin
    if (addr == '0) begin
      data = ZERO_WORD;
    end else if (wen && (wb_rd == addr)) begin
      data = wb_data;
    end else begin
      data = rf_data;
    end
  end

endmodule

// File: rtl/ysyx_22050078_wbu.sv
// Write-back unit: LSU/EXU arbitration into one WB register, busy scoreboard,
// and operand forwarding for the IDU.
module ysyx_22050078_wbu
  import ysyx_22050078_wbu_pkg::*;
(
  input logic             clk,
  input logic             rst,
  ysyx_22050078_wbu_if.slave bus
);

  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] busy_nxt;
  wb_entry_t          wb_q;
  logic               err_q;

  wb_src_e   src;
  logic      res_fire;
  reg_addr_t res_rd;
  word_t     res_data;
  logic      iss_fire;

  assign bus.lsu_ready = ~rst;
  assign bus.exu_ready = ~rst & ~bus.lsu_valid;

  // Not bypassed by a same-cycle clear: a WAW stall ends one cycle after the result.
  assign bus.iss_ready = ~busy[bus.iss_rd];
  assign iss_fire      = bus.iss_valid & bus.iss_ready;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    src      = SRC_NONE;
    res_rd   = '0;
    res_data = ZERO_WORD;
    if (bus.lsu_valid && bus.lsu_ready) begin
      src      = SRC_LSU;
      res_rd   = bus.lsu_rd;
      res_data = bus.lsu_data;
    end else if (bus.exu_valid && bus.exu_ready) begin
      src      = SRC_EXU;
      res_rd   = bus.exu_rd;
      res_data = bus.exu_data;
    end
  end

  assign res_fire = (src != SRC_NONE);

  always_comb begin
    busy_nxt = busy;
    if (res_fire) busy_nxt[res_rd] = 1'b0;
    // Set applied after clear: a new issue to the same rd keeps ownership.
    if (iss_fire) busy_nxt[bus.iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= '0;
      wb_q  <= '0;
      err_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      busy     <= busy_nxt;
      wb_q.vld <= res_fire;
      if (res_fire) begin
        wb_q.rd   <= res_rd;
        wb_q.data <= res_data;
      end
      if (res_fire && (res_rd != '0) && !busy[res_rd]) err_q <= 1'b1;
    end
  end

  assign bus.rf_wen      = wb_q.vld & (wb_q.rd != '0);
  assign bus.rf_waddr    = wb_q.rd;
  assign bus.rf_wdata    = wb_q.data;
  assign bus.rf_rs1_addr = bus.rs1_addr;
  assign bus.rf_rs2_addr = bus.rs2_addr;
  assign bus.rs1_busy    = busy[bus.rs1_addr];
  assign bus.rs2_busy    = busy[bus.rs2_addr];
  assign bus.err         = err_q;

  ysyx_22050078_wbu_fwd u_fwd_rs1 (
    .addr    (bus.rs1_addr),
    .rf_data (bus.rf_rs1_data),
    .wen     (bus.rf_wen),
    .wb_rd   (wb_q.rd),
    .wb_data (wb_q.data),
    .data    (bus.rs1_data)
  );

  ysyx_22050078_wbu_fwd u_fwd_rs2 (
    .addr    (bus.rs2_addr),
    .rf_data (bus.rf_rs2_data),
    .wen     (bus.rf_wen),
    .wb_rd   (wb_q.rd),
    .wb_data (wb_q.data),
    .data    (bus.rs2_data)
  );

endmodule

// File: tb/tb_ysyx_22050078_wbu.sv
// Bench for the write-back unit: directed scenarios plus random traffic against
// an architectural model (busy set, committed register values, last write).
module tb_ysyx_22050078_wbu;
  import ysyx_22050078_wbu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_22050078_wbu_if bus ();

  ysyx_22050078_wbu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file attached to the write port.
  logic [63:0] regs [REG_NUM] = '{default: '0};
  assign bus.rf_rs1_data = regs[bus.rf_rs1_addr];
  assign bus.rf_rs2_data = regs[bus.rf_rs2_addr];
  always @(posedge clk) if (bus.rf_wen === 1'b1) regs[bus.rf_waddr] <= bus.rf_wdata;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural model: who is pending, what each register holds once committed.
  bit          m_busy [REG_NUM];
  logic [63:0] m_arch [REG_NUM] = '{default: '0};
  bit          m_wb_vld  = 1'b0;
  int          m_wb_rd   = 0;
  logic [63:0] m_wb_data = '0;
  bit          m_err     = 1'b0;
  bit          cmp_en    = 1'b0;

  always @(posedge clk) begin : model
    int          rd;
    logic [63:0] d;
    bit          iss_go;
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) m_busy[i] = 1'b0;
      m_wb_vld  = 1'b0;
      m_wb_rd   = 0;
      m_wb_data = '0;
      m_err     = 1'b0;
    end else begin
      iss_go = bus.iss_valid && !m_busy[bus.iss_rd] && (bus.iss_rd != 0);
      if (bus.lsu_valid || bus.exu_valid) begin
        rd = bus.lsu_valid ? int'(bus.lsu_rd) : int'(bus.exu_rd);
        d  = bus.lsu_valid ? bus.lsu_data : bus.exu_data;
        if (rd != 0) begin
          if (!m_busy[rd]) m_err = 1'b1;
          m_busy[rd] = 1'b0;
          m_arch[rd] = d;
        end
        m_wb_vld  = 1'b1;
        m_wb_rd   = rd;
        m_wb_data = d;
      end else begin
        m_wb_vld = 1'b0;
      end
      if (iss_go) m_busy[bus.iss_rd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("iss_ready", bus.iss_ready, !m_busy[bus.iss_rd]);
      check("lsu_ready", bus.lsu_ready, !rst);
      check("exu_ready", bus.exu_ready, !rst && !bus.lsu_valid);
      check("rf_wen", bus.rf_wen, m_wb_vld && (m_wb_rd != 0));
      check("rf_waddr", bus.rf_waddr, m_wb_rd);
      check("rf_wdata", bus.rf_wdata, m_wb_data);
      check("rf_rs1_addr", bus.rf_rs1_addr, bus.rs1_addr);
      check("rf_rs2_addr", bus.rf_rs2_addr, bus.rs2_addr);
      check("rs1_data", bus.rs1_data, (bus.rs1_addr == 0) ? 64'd0 : m_arch[bus.rs1_addr]);
      check("rs2_data", bus.rs2_data, (bus.rs2_addr == 0) ? 64'd0 : m_arch[bus.rs2_addr]);
      check("rs1_busy", bus.rs1_busy, m_busy[bus.rs1_addr]);
      check("rs2_busy", bus.rs2_busy, m_busy[bus.rs2_addr]);
      check("err", bus.err, m_err);
    end
  end

  task automatic idle();
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.exu_valid = 1'b0; bus.exu_rd = '0; bus.exu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.rs1_addr  = '0;   bus.rs2_addr = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset_rf_wen", bus.rf_wen, 1'b0);
    check("reset_wdata", bus.rf_wdata, 64'd0);
    check("reset_iss_ready", bus.iss_ready, 1'b1);
    next();

    // Issue rd=5, then resolve it from EXU and see the forward.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    next();
    bus.iss_valid = 1'b0; bus.rs1_addr = 5'd5;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_data = 64'h1234;
    @(negedge clk);
    check("t1_rs1_busy", bus.rs1_busy, 1'b1);
    check("t1_iss_ready", bus.iss_ready, 1'b0);
    next();
    idle(); bus.rs1_addr = 5'd5;
    @(negedge clk);
    check("t1_wen", bus.rf_wen, 1'b1);
    check("t1_waddr", bus.rf_waddr, 5'd5);
    check("t1_wdata", bus.rf_wdata, 64'h1234);
    check("t1_fwd", bus.rs1_data, 64'h1234);
    check("t1_busy_clr", bus.rs1_busy, 1'b0);
    next();

    // LSU beats EXU in the same cycle.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    next();
    bus.iss_rd = 5'd4;
    next();
    idle();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 64'hAA;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd4; bus.exu_data = 64'hBB;
    @(negedge clk);
    check("t2_exu_ready", bus.exu_ready, 1'b0);
    next();
    bus.lsu_valid = 1'b0; bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd4;
    @(negedge clk);
    check("t2_lsu_waddr", bus.rf_waddr, 5'd3);
    check("t2_lsu_wdata", bus.rf_wdata, 64'hAA);
    check("t2_busy3", bus.rs1_busy, 1'b0);
    check("t2_busy4", bus.rs2_busy, 1'b1);
    next();
    idle(); bus.rs2_addr = 5'd4;
    @(negedge clk);
    check("t2_exu_waddr", bus.rf_waddr, 5'd4);
    check("t2_exu_wdata", bus.rf_wdata, 64'hBB);
    check("t2_busy4_clr", bus.rs2_busy, 1'b0);
    next();

    // Result to x0.
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd0; bus.exu_data = 64'hFFFF;
    next();
    idle();
    @(negedge clk);
    check("t4_wen", bus.rf_wen, 1'b0);
    check("t4_rs1_zero", bus.rs1_data, 64'd0);
    check("t4_err", bus.err, 1'b0);
    next();

    // Unowned destination raises a sticky error cleared only by reset.
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd9; bus.exu_data = 64'h99;
    next();
    idle();
    @(negedge clk);
    check("t5_wen", bus.rf_wen, 1'b1);
    check("t5_waddr", bus.rf_waddr, 5'd9);
    check("t5_err", bus.err, 1'b1);
    next();
    @(negedge clk);
    check("t5_err_sticky", bus.err, 1'b1);
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    @(negedge clk);
    check("t5_err_reset", bus.err, 1'b0);
    next();

    // Issue and result to rd=7 on the same edge: the issue keeps busy[7].
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd7; bus.exu_data = 64'h70;
    next();
    idle(); bus.iss_rd = 5'd7; bus.rs1_addr = 5'd7;
    @(negedge clk);
    check("t3_busy7", bus.rs1_busy, 1'b1);
    check("t3_iss_ready", bus.iss_ready, 1'b0);
    next();

    // Reset with pending issues and a loaded WB register.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd2;
    next();
    bus.iss_rd = 5'd6;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd7; bus.exu_data = 64'h5;
    next();
    idle();
    rst = 1'b1;
    next();
    rst = 1'b0;
    bus.iss_rd = 5'd6; bus.rs1_addr = 5'd2; bus.rs2_addr = 5'd6;
    @(negedge clk);
    check("t6_busy2", bus.rs1_busy, 1'b0);
    check("t6_busy6", bus.rs2_busy, 1'b0);
    check("t6_wen", bus.rf_wen, 1'b0);
    check("t6_iss_ready", bus.iss_ready, 1'b1);
    next();

    // Random traffic on a small register window to provoke collisions.
    for (int c = 0; c < 3000; c++) begin
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_rd    = 5'($urandom_range(0, 7));
      bus.exu_valid = 1'($urandom_range(0, 1));
      bus.exu_rd    = 5'($urandom_range(0, 7));
      bus.exu_data  = {$urandom, $urandom};
      bus.lsu_valid = ($urandom_range(0, 3) == 0);
      bus.lsu_rd    = 5'($urandom_range(0, 7));
      bus.lsu_data  = {$urandom, $urandom};
      bus.rs1_addr  = 5'($urandom_range(0, 8));
      bus.rs2_addr  = 5'($urandom_range(0, 31));
      rst           = ($urandom_range(0, 63) == 0);
      next();
    end

    rst = 1'b0;
    idle();
    repeat (3) next();
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
